// File: rtl/time_capture_writer.sv
// time_capture_writer
//   Producer side of the time-domain display RAM. It captures one triggered,
//   decimated and clipped frame of signed audio samples, oscilloscope style,
//   and writes it through RAM port A. After each frame it holds off for a
//   programmable number of cycles and then re-arms.
//
// Ports
//   ck100MHz     in   system clock, rising edge
//   reset        in   synchronous, active-high reset
//   sampleValid  in   one-cycle strobe qualifying sampleData
//   sampleData   in   signed audio sample
//   decim        in   keep one of every decim+1 samples while capturing
//   trigEn       in   1 = level trigger, 0 = free-run
//   trigLevel    in   signed trigger threshold (strict rising crossing)
//   enaTime      out  RAM port-A enable (same as weaTime)
//   weaTime      out  RAM port-A write strobe
//   addraTime    out  RAM write address
//   dinaTime     out  clipped sample being written
//   capturing    out  high while in the CAPTURE state
//   frameDone    out  one-cycle pulse together with the last write
module time_capture_writer #(
  parameter int DATA_W         = 8,
  parameter int NUM_POINTS     = 640,
  parameter int HOLDOFF_CYCLES = 1666666,
  parameter int TRIG_TIMEOUT   = 4096,
  parameter int CLIP_HI        = 119,
  parameter int CLIP_LO        = -120
) (
  input  logic                     ck100MHz,
  input  logic                     reset,
  input  logic                     sampleValid,
  input  logic signed [DATA_W-1:0] sampleData,
  input  logic [3:0]               decim,
  input  logic                     trigEn,
  input  logic signed [DATA_W-1:0] trigLevel,
  output logic                     enaTime,
  output logic                     weaTime,
  output logic [9:0]               addraTime,
  output logic signed [DATA_W-1:0] dinaTime,
  output logic                     capturing,
  output logic                     frameDone
);

  localparam int TMO_W = $clog2(TRIG_TIMEOUT + 1);
  localparam int HO_W  = $clog2(HOLDOFF_CYCLES + 1);

  localparam logic [TMO_W-1:0]         TMO_LAST = TMO_W'(TRIG_TIMEOUT - 1);
  localparam logic [HO_W-1:0]          HO_LAST  = HO_W'(HOLDOFF_CYCLES - 1);
  localparam logic [9:0]               PT_LAST  = 10'(NUM_POINTS - 1);
  localparam logic signed [DATA_W-1:0] HI       = DATA_W'(CLIP_HI);
  localparam logic signed [DATA_W-1:0] LO       = DATA_W'(CLIP_LO);

  typedef enum logic [1:0] {
    ARM     = 2'd0,
    CAPTURE = 2'd1,
    HOLDOFF = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [9:0]               pt_cnt;
  logic [3:0]               dec_cnt;
  logic [TMO_W-1:0]         tmo_cnt;
  logic [HO_W-1:0]          ho_cnt;
  logic signed [DATA_W-1:0] prevSample;
  logic                     prevValid;

  logic                     crossing;
  logic                     wr_p0;
  logic                     last_p0;
  logic signed [DATA_W-1:0] data_p0;

  // Bound the sample so that 120 - sample stays inside the display rows.
  function automatic logic signed [DATA_W-1:0] clip(input logic signed [DATA_W-1:0] s);
    if (s > HI)      return HI;
    else if (s < LO) return LO;
    else             return s;
  endfunction

  assign capturing = (state == CAPTURE);

  // Stage p0: trigger / keep decision on the incoming sample
  always_comb begin
    state_nxt = state;
    wr_p0     = 1'b0;
    crossing  = prevValid && (prevSample < trigLevel) && (sampleData >= trigLevel);
    data_p0   = clip(sampleData);
    case (state)
      ARM: begin
        if (sampleValid && (!trigEn || crossing || (tmo_cnt == TMO_LAST))) begin
          wr_p0     = 1'b1;
          state_nxt = (pt_cnt == PT_LAST) ? HOLDOFF : CAPTURE;
        end
      end
      CAPTURE: begin
        if (sampleValid && (dec_cnt == decim)) begin
          wr_p0 = 1'b1;
          if (pt_cnt == PT_LAST) state_nxt = HOLDOFF;
        end
      end
      HOLDOFF: begin
        if (ho_cnt == HO_LAST) state_nxt = ARM;
      end
      default: state_nxt = ARM;
    endcase
    last_p0 = wr_p0 && (pt_cnt == PT_LAST);
  end

  // Stage p1: registered RAM write port and control counters
  always_ff @(posedge ck100MHz) begin
    if (reset) begin
      state     <= ARM;
      pt_cnt    <= '0;
      dec_cnt   <= '0;
      tmo_cnt   <= '0;
      ho_cnt    <= '0;
      prevValid <= 1'b0;
      enaTime   <= 1'b0;
      weaTime   <= 1'b0;
      frameDone <= 1'b0;
      addraTime <= '0;
      dinaTime  <= '0;
    end else begin
      state     <= state_nxt;
      enaTime   <= wr_p0;
      weaTime   <= wr_p0;
      frameDone <= last_p0;
      if (sampleValid) prevValid <= 1'b1;

      if (wr_p0) begin
        addraTime <= pt_cnt;
        dinaTime  <= data_p0;
        pt_cnt    <= last_p0 ? 10'd0 : pt_cnt + 10'd1;
      end

      case (state)
        ARM: begin
          if (sampleValid) begin
            if (wr_p0) begin
              tmo_cnt <= '0;
              dec_cnt <= '0;
            end else begin
              tmo_cnt <= tmo_cnt + 1'b1;
            end
          end
        end
        CAPTURE: begin
          // Not reset on a live decim change: a counter above the new
          // decim simply wraps through 15 back to 0.
          if (sampleValid) dec_cnt <= (dec_cnt == decim) ? 4'd0 : dec_cnt + 4'd1;
        end
        HOLDOFF: begin
          if (ho_cnt == HO_LAST) begin
            ho_cnt  <= '0;
            tmo_cnt <= '0;
          end else begin
            ho_cnt <= ho_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Previous sample tracks every valid input regardless of state
  always_ff @(posedge ck100MHz) begin
    if (sampleValid) prevSample <= sampleData;
  end

endmodule

// File: tb/tb_time_capture_writer.sv
module tb_time_capture_writer;

  localparam int NP = 8;
  localparam int HO = 20;
  localparam int TO = 16;

  logic              ck100MHz = 1'b0;
  logic              reset;
  logic              sampleValid;
  logic signed [7:0] sampleData;
  logic [3:0]        decim;
  logic              trigEn;
  logic signed [7:0] trigLevel;
  logic              enaTime;
  logic              weaTime;
  logic [9:0]        addraTime;
  logic signed [7:0] dinaTime;
  logic              capturing;
  logic              frameDone;

  int checks = 0;
  int errors = 0;

  time_capture_writer #(
    .DATA_W(8),
    .NUM_POINTS(NP),
    .HOLDOFF_CYCLES(HO),
    .TRIG_TIMEOUT(TO),
    .CLIP_HI(119),
    .CLIP_LO(-120)
  ) dut (
    .ck100MHz(ck100MHz),
    .reset(reset),
    .sampleValid(sampleValid),
    .sampleData(sampleData),
    .decim(decim),
    .trigEn(trigEn),
    .trigLevel(trigLevel),
    .enaTime(enaTime),
    .weaTime(weaTime),
    .addraTime(addraTime),
    .dinaTime(dinaTime),
    .capturing(capturing),
    .frameDone(frameDone)
  );

  always #5 ck100MHz = ~ck100MHz;

  task automatic tick();
    @(posedge ck100MHz);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_write(input string tag, input int addr, input int data, input bit last);
    chk({tag, ".we"}, weaTime, 1);
    chk({tag, ".ena"}, enaTime, 1);
    chk({tag, ".addr"}, addraTime, addr);
    chk({tag, ".din"}, dinaTime, data);
    chk({tag, ".done"}, frameDone, last);
  endtask

  int nstrobe;
  int v;
  int clip_in  [8] = '{127, -128, 119, -120, 0, 0, 0, 0};
  int clip_exp [8] = '{119, -120, 119, -120, 0, 0, 0, 0};
  int lvl_seq  [7] = '{20, 12, 11, 0, 5, 9, 10};

  initial begin
    reset       = 1'b1;
    sampleValid = 1'b0;
    sampleData  = '0;
    decim       = 4'd0;
    trigEn      = 1'b0;
    trigLevel   = 8'sd0;
    tick();
    tick();
    chk("rst.we", weaTime, 0);
    chk("rst.ena", enaTime, 0);
    chk("rst.addr", addraTime, 0);
    chk("rst.din", dinaTime, 0);
    chk("rst.cap", capturing, 0);
    chk("rst.done", frameDone, 0);
    reset = 1'b0;

    // Free-run ramp 115..122, crossing the upper clip limit
    sampleValid = 1'b1;
    for (int i = 0; i < NP; i++) begin
      v = 115 + i;
      sampleData = 8'(v);
      tick();
      chk_write("free", i, (v > 119) ? 119 : v, i == NP - 1);
      chk("free.cap", capturing, (i == NP - 1) ? 0 : 1);
    end

    // Holdoff: valid samples keep arriving but nothing is written
    sampleData = 8'sd0;
    nstrobe = 0;
    for (int i = 0; i < HO; i++) begin
      tick();
      nstrobe += int'(weaTime);
    end
    chk("holdoff.strobes", nstrobe, 0);
    chk("holdoff.cap", capturing, 0);
    tick();
    chk_write("rearm", 0, 0, 0);

    // Partial frame then reset mid-capture
    for (int i = 1; i < 5; i++) begin
      sampleData = 8'(i);
      tick();
      chk_write("partial", i, i, 0);
    end
    reset = 1'b1;
    sampleData = 8'sd50;
    tick();
    chk("midrst.we", weaTime, 0);
    chk("midrst.done", frameDone, 0);
    chk("midrst.addr", addraTime, 0);
    chk("midrst.din", dinaTime, 0);
    chk("midrst.cap", capturing, 0);
    reset = 1'b0;

    // Level trigger at 10: first sample after reset, falling 12,11 and
    // sub-threshold values must not fire; 9 -> 10 fires
    trigEn    = 1'b1;
    trigLevel = 8'sd10;
    for (int i = 0; i < 7; i++) begin
      sampleData = 8'(lvl_seq[i]);
      tick();
      if (i < 6) begin
        chk("lvl.idle.we", weaTime, 0);
        chk("lvl.idle.addr", addraTime, 0);
        chk("lvl.idle.din", dinaTime, 0);
      end
    end
    chk_write("lvl.trig", 0, 10, 0);
    chk("lvl.cap", capturing, 1);

    // Decimation by 4 with a sample every other cycle
    decim = 4'd3;
    for (int k = 1; k < NP; k++) begin
      for (int s = 1; s <= 4; s++) begin
        sampleValid = 1'b1;
        sampleData  = 8'(10 + 4 * (k - 1) + s);
        tick();
        if (s == 4) chk_write("decim", k, 10 + 4 * k, k == NP - 1);
        else        chk("decim.drop", weaTime, 0);
        chk("decim.cap", capturing, (k == NP - 1 && s == 4) ? 0 : 1);
        sampleValid = 1'b0;
        tick();
        chk("decim.gap.we", weaTime, 0);
        chk("decim.gap.addr", addraTime, k - ((s == 4) ? 0 : 1));
      end
    end
    decim = 4'd0;
    for (int i = 0; i < HO; i++) tick();

    // Clipping at both limits
    trigEn = 1'b0;
    sampleValid = 1'b1;
    for (int i = 0; i < NP; i++) begin
      sampleData = 8'(clip_in[i]);
      tick();
      chk_write("clip", i, clip_exp[i], i == NP - 1);
    end
    sampleValid = 1'b0;
    for (int i = 0; i < HO; i++) tick();

    // Auto-trigger: level never crossed, fires on valid sample #TO
    trigEn      = 1'b1;
    trigLevel   = 8'sd50;
    sampleData  = 8'sd0;
    sampleValid = 1'b1;
    nstrobe = 0;
    for (int i = 0; i < TO - 1; i++) begin
      tick();
      nstrobe += int'(weaTime);
    end
    chk("auto.wait.strobes", nstrobe, 0);
    tick();
    chk_write("auto.trig", 0, 0, 0);
    for (int i = 1; i < NP; i++) begin
      tick();
      chk_write("auto", i, 0, i == NP - 1);
    end
    sampleValid = 1'b0;
    tick();
    chk("auto.after.we", weaTime, 0);
    chk("auto.after.done", frameDone, 0);
    chk("auto.after.addr", addraTime, NP - 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
